// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core: one FSM shares a single ALU across FETCH..WB, with req/ready imem/dmem buses.
// Optional feature: define MIPS_MC_BNE_EN to decode opcode 6'h05 as bne.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ready,
  input  logic [31:0]       i_imem_data,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_ready,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_retire
);
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'h05;
`endif

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_simm, r_aluout, r_mdr;
  logic [31:0] r_rf [32];
  logic        r_imem_req, r_dmem_req, r_dmem_we, r_retire;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_wb_dst;
  logic [31:0] w_pc4, w_br_tgt, w_jmp_tgt, w_alu_b, w_alu_res, w_wb_data;
  logic        w_alu_ok, w_is_br, w_br_taken, w_is_mem;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_funct   = r_ir[5:0];
  assign w_pc4     = r_pc + 32'd4;
  assign w_br_tgt  = w_pc4 + {r_simm[29:0], 2'b00};
  assign w_jmp_tgt = {w_pc4[31:28], r_ir[25:0], 2'b00};
  assign w_alu_b   = (w_op == OP_R) ? r_b : r_simm;
  assign w_is_mem  = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_wb_dst  = (w_op == OP_R) ? w_rd : w_rt;
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_aluout;

`ifdef MIPS_MC_BNE_EN
  assign w_is_br    = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_br_taken = (w_op == OP_BNE) ? (r_a != r_b) : (r_a == r_b);
`else
  assign w_is_br    = (w_op == OP_BEQ);
  assign w_br_taken = (r_a == r_b);
`endif

  // Shared ALU; w_alu_ok low flags an illegal opcode/funct, which retires as a NOP.
  always_comb begin
    w_alu_res = r_a + w_alu_b;
    w_alu_ok  = 1'b0;
    case (w_op)
      OP_R: begin
        w_alu_ok = 1'b1;
        case (w_funct)
          6'h20:   w_alu_res = r_a + r_b;
          6'h22:   w_alu_res = r_a - r_b;
          6'h24:   w_alu_res = r_a & r_b;
          6'h25:   w_alu_res = r_a | r_b;
          6'h2A:   w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
          default: w_alu_ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: w_alu_ok = 1'b1;
      default:               w_alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_simm     <= '0;
      r_aluout   <= '0;
      r_mdr      <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_retire   <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: if (i_imem_ready) begin
          r_ir       <= i_imem_data;
          r_imem_req <= 1'b0;
          r_state    <= S_DECODE;
        end
        S_DECODE: begin
          r_a    <= r_rf[w_rs];
          r_b    <= r_rf[w_rt];
          r_simm <= {{16{r_ir[15]}}, r_ir[15:0]};
          if (w_op == OP_J) begin
            r_pc       <= w_jmp_tgt;
            r_retire   <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_br || !w_alu_ok) begin
            r_pc       <= (w_is_br && w_br_taken) ? w_br_tgt : w_pc4;
            r_retire   <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_aluout <= w_alu_res;
            if (w_is_mem) begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (w_op == OP_SW);
              r_state    <= S_MEM;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_MEM: if (i_dmem_ready) begin
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          if (w_op == OP_SW) begin
            r_pc       <= w_pc4;
            r_retire   <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_mdr   <= i_dmem_rdata;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_rf[w_wb_dst] <= w_wb_data;
          r_pc       <= w_pc4;
          r_retire   <= 1'b1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc[ADDR_W-1:0];
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_aluout[ADDR_W-1:0];
  assign o_dmem_wdata = r_b;
  assign o_retire     = r_retire;
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: program in a bench imem, scoreboard of retire PCs/CPI and dmem accesses.
module tb_mips_multicycle;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;

  mips_multicycle #(.RESET_PC(32'h100), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ready(imem_ready), .i_imem_data(imem_data),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata), .o_retire(retire)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wd; } dm_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] exp_pc [$];
  int          exp_cpi [$];
  dm_t         exp_dm [$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_ret = 0, icnt = 0, dcnt = 0;
  int imem_wait = 0, dmem_wait = 3;
  bit chk_en = 1'b1, first_ret = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn[5:0]};
  endfunction
  function automatic logic [31:0] f_j(input int tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  task automatic ld(input int a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask
  task automatic exp_ret(input int pc, input int cpi);
    exp_pc.push_back(32'(pc));
    exp_cpi.push_back(cpi);
  endtask
  task automatic exp_mem(input int we, input int a, input int wd);
    dm_t e;
    e.we = we[0]; e.addr = 32'(a); e.wd = 32'(wd);
    exp_dm.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Memory responders plus scoreboard pops; everything sampled on the falling edge.
  always @(negedge clk) begin
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    if (imem_req) begin
      if (icnt >= imem_wait) begin
        imem_ready = 1'b1;
        imem_data  = imem[imem_addr[9:2]];
        icnt = 0;
      end else icnt++;
    end else icnt = 0;
    if (dmem_req) begin
      if (dcnt >= dmem_wait) begin
        dm_t e;
        dmem_ready = 1'b1;
        dcnt = 0;
        if (chk_en && exp_dm.size() > 0) begin
          e = exp_dm.pop_front();
          check("dm_we", {31'd0, dmem_we}, {31'd0, e.we});
          check("dm_addr", dmem_addr, e.addr);
          if (e.we) check("dm_wdata", dmem_wdata, e.wd);
        end
        if (dmem_we) dmem[dmem_addr[7:2]] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr[7:2]];
      end else dcnt++;
    end else dcnt = 0;
    if (retire && chk_en && exp_pc.size() > 0) begin
      int c;
      check("ret_pc", imem_addr, exp_pc.pop_front());
      c = exp_cpi.pop_front();
      if (!first_ret) check("ret_cpi", 32'(cyc - last_ret), 32'(c));
      first_ret = 1'b0;
      last_ret = cyc;
    end
  end

  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_data = '0; dmem_rdata = '0;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;

    ld(32'h100, f_i(8, 0, 1, 5));         exp_ret(32'h104, 4);
    ld(32'h104, f_i(8, 0, 2, 7));         exp_ret(32'h108, 4);
    ld(32'h108, f_r(1, 2, 3, 32'h20));    exp_ret(32'h10C, 4);
    ld(32'h10C, f_i(32'h2B, 0, 3, 4));    exp_ret(32'h110, 7); exp_mem(1, 4, 12);
    ld(32'h110, f_i(32'h23, 0, 4, 4));    exp_ret(32'h114, 8); exp_mem(0, 4, 0);
    ld(32'h114, f_i(32'h2B, 0, 4, 8));    exp_ret(32'h118, 7); exp_mem(1, 8, 12);
    ld(32'h118, f_i(8, 0, 7, 1));         exp_ret(32'h11C, 4);
    ld(32'h11C, f_r(0, 7, 5, 32'h22));    exp_ret(32'h120, 4);
    ld(32'h120, f_r(5, 0, 6, 32'h2A));    exp_ret(32'h124, 4);
    ld(32'h124, f_i(8, 0, 0, 9));         exp_ret(32'h128, 4);
    ld(32'h128, f_i(32'h2B, 0, 5, 12));   exp_ret(32'h12C, 7); exp_mem(1, 12, 32'hFFFF_FFFF);
    ld(32'h12C, f_i(32'h2B, 0, 6, 16));   exp_ret(32'h130, 7); exp_mem(1, 16, 1);
    ld(32'h130, f_i(32'h2B, 0, 0, 20));   exp_ret(32'h134, 7); exp_mem(1, 20, 0);
    ld(32'h134, f_r(1, 2, 8, 32'h24));    exp_ret(32'h138, 4);
    ld(32'h138, f_r(1, 2, 9, 32'h25));    exp_ret(32'h13C, 4);
    ld(32'h13C, f_i(32'h2B, 0, 8, 24));   exp_ret(32'h140, 7); exp_mem(1, 24, 5);
    ld(32'h140, f_i(32'h2B, 0, 9, 28));   exp_ret(32'h144, 7); exp_mem(1, 28, 7);
    ld(32'h144, f_i(4, 1, 2, 2));         exp_ret(32'h148, 3);
    ld(32'h148, f_i(4, 1, 1, 1));         exp_ret(32'h150, 3);
    ld(32'h14C, f_i(8, 0, 1, 99));
    ld(32'h150, f_i(5, 1, 2, 1));
`ifdef MIPS_MC_BNE_EN
    exp_ret(32'h158, 3);
`else
    exp_ret(32'h154, 3);
`endif
    ld(32'h154, f_r(2, 2, 1, 32'h3F));
`ifndef MIPS_MC_BNE_EN
    exp_ret(32'h158, 3);
`endif
    ld(32'h158, f_i(32'h2B, 0, 1, 32));   exp_ret(32'h15C, 7); exp_mem(1, 32, 5);
    ld(32'h15C, f_j(3));                  exp_ret(32'h00C, 2);
    ld(32'h00C, f_i(4, 1, 2, 2));         exp_ret(32'h010, 3);
    ld(32'h010, f_i(4, 1, 1, -1));
    for (int k = 0; k < 3; k++) exp_ret(32'h010, 3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h100);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("boot_imem_req", {31'd0, imem_req}, 32'd1);

    for (int t = 0; t < 3000 && exp_pc.size() > 0; t++) @(posedge clk);
    check("sb_ret_left", 32'(exp_pc.size()), 32'd0);
    check("sb_dm_left", 32'(exp_dm.size()), 32'd0);

    // Reset while a store is stalled in MEM must drop dmem_req asynchronously.
    chk_en = 1'b0;
    @(negedge clk); rst = 1'b1; dmem_wait = 50;
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 300 && !dmem_req; t++) @(posedge clk);
    check("mid_mem_req_seen", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    check("mid_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("mid_rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pc", imem_addr, 32'h100);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
